// File: rtl/phy_pkg.sv
// Shared definitions for the PHY transmit serializer.
// Holds the link state enumeration and the default idle/comma symbol.
package phy_pkg;

  // OFF: link down, all outputs quiet. SYNC: idle words only. ACTIVE: data accepted.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } phy_state_t;

  // K28.5-style comma used as the idle word on every lane.
  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

endpackage

// File: rtl/phy_tx_serializer_if.sv
// Parallel-side bus of the PHY transmit serializer.
//   data_in     : NUM_CH packed words, lane k at [k*DATA_W +: DATA_W]
//   valid_in    : per-lane word valid
//   word_strobe : one-cycle word-boundary pulse from the serializer
//   data_out    : per-lane serial bit, MSB first
//   active      : link sync complete, lanes carry data
// master = word source / observer, slave = serializer.
interface phy_tx_serializer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8
);

  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        valid_in;
  logic                     word_strobe;
  logic [NUM_CH-1:0]        data_out;
  logic                     active;

  modport master (
    output data_in,
    output valid_in,
    input  word_strobe,
    input  data_out,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output word_strobe,
    output data_out,
    output active
  );

endinterface

// File: rtl/phy_tx_lane.sv
// One serializer lane: a DATA_W shift register with clear/load/shift.
//   clk_8f  : bit-rate clock
//   reset   : asynchronous active-high reset
//   clear   : synchronous clear of the lane (link off)
//   load    : load a new word this edge
//   word    : word to load
//   bit_out : registered serial bit, MSB first
module phy_tx_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic              bit_out
);

  // Holds the bits still to be sent; its MSB is the next bit to go out.
  logic [DATA_W-1:0] shift_reg;

  // Lane register: clear has priority, then load, otherwise shift left by one.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      shift_reg <= {DATA_W{1'b0}};
      bit_out   <= 1'b0;
    end else if (clear) begin
      shift_reg <= {DATA_W{1'b0}};
      bit_out   <= 1'b0;
    end else if (load) begin
      // The word's MSB goes straight to the output register so it appears
      // the cycle after the load edge; the remainder waits in shift_reg.
      bit_out   <= word[DATA_W-1];
      shift_reg <= {word[DATA_W-2:0], 1'b0};
    end else begin
      bit_out   <= shift_reg[DATA_W-1];
      shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/phy_tx_serializer.sv
// Multi-lane PHY transmit serializer.
// After enable, SYNC_WORDS idle words are sent on all lanes, then per-lane
// words are accepted at each word boundary and shifted out MSB first.
//   clk_8f : bit-rate clock (all logic on its rising edge)
//   reset  : asynchronous active-high reset
//   enable : transmitter enable; low forces the link off on the next edge
//   bus    : data_in / valid_in in, word_strobe / data_out / active out
module phy_tx_serializer
  import phy_pkg::*;
#(
  parameter int                NUM_CH     = 2,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(IDLE_SYM_DEFAULT),
  parameter int                SYNC_WORDS = 4
) (
  input  logic                 clk_8f,
  input  logic                 reset,
  input  logic                 enable,
  phy_tx_serializer_if.slave   bus
);

  localparam int BIT_W  = $clog2(DATA_W);
  localparam int SYNC_W = $clog2(SYNC_WORDS + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);
  localparam logic [SYNC_W-1:0] SYNC_DONE = SYNC_W'(SYNC_WORDS);

  phy_state_t        state, state_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [SYNC_W-1:0] sync_cnt, sync_cnt_next;
  logic              active, active_next;
  logic              word_strobe;
  logic              lane_clear;
  logic              lane_load;
  logic [NUM_CH-1:0] lane_bits;

  assign word_strobe = (state != ST_OFF) && (bit_cnt == BIT_LAST);
  // Lanes are cleared on the edge that turns the link off and stay clear in OFF.
  assign lane_clear  = !enable || (state == ST_OFF);
  assign lane_load   = word_strobe && enable;

  // State, counters and the active flag.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state    <= ST_OFF;
      bit_cnt  <= {BIT_W{1'b0}};
      sync_cnt <= {SYNC_W{1'b0}};
      active   <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      sync_cnt <= sync_cnt_next;
      active   <= active_next;
    end
  end

  // Next-state logic: word counting in SYNC, bit counting in SYNC and ACTIVE.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    sync_cnt_next = sync_cnt;
    if (!enable) begin
      state_next    = ST_OFF;
      bit_cnt_next  = {BIT_W{1'b0}};
      sync_cnt_next = {SYNC_W{1'b0}};
    end else begin
      case (state)
        ST_OFF: begin
          state_next    = ST_SYNC;
          bit_cnt_next  = {BIT_W{1'b0}};
          sync_cnt_next = {SYNC_W{1'b0}};
        end
        ST_SYNC: begin
          if (word_strobe) begin
            bit_cnt_next = {BIT_W{1'b0}};
            // The edge performing the last idle load also enters ACTIVE; the
            // word loaded on that edge is still idle since state is SYNC.
            if (sync_cnt == SYNC_LAST) begin
              state_next    = ST_ACTIVE;
              sync_cnt_next = SYNC_DONE;
            end else begin
              sync_cnt_next = sync_cnt + SYNC_W'(1);
            end
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (word_strobe) begin
            bit_cnt_next = {BIT_W{1'b0}};
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
        default: begin
          state_next    = ST_OFF;
          bit_cnt_next  = {BIT_W{1'b0}};
          sync_cnt_next = {SYNC_W{1'b0}};
        end
      endcase
    end
    active_next = (state_next == ST_ACTIVE);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [DATA_W-1:0] lane_word;

    // Each lane independently sends its word when valid, otherwise the idle symbol.
    assign lane_word = ((state == ST_ACTIVE) && bus.valid_in[k])
                       ? bus.data_in[k*DATA_W +: DATA_W] : IDLE_SYM;

    phy_tx_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk_8f  (clk_8f),
      .reset   (reset),
      .clear   (lane_clear),
      .load    (lane_load),
      .word    (lane_word),
      .bit_out (lane_bits[k])
    );
  end

  assign bus.word_strobe = word_strobe;
  assign bus.data_out    = lane_bits;
  assign bus.active      = active;

endmodule
